reg_wb_sched: RTL
=================

Name: reg_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard for the 256-entry, 65-bit register bank.
- Shares the bank's single write port among N_REQ write-back requesters (ALU, load unit, etc.) using a round-robin valid/ready arbiter.
- Drives the bank's write_en, write_address and write_data from registered outputs.
- Tracks per-register "pending write" bits so issue logic can detect read-after-write hazards on the bank's two read ports.

Parameters:
- N_REQ, 3, number of write-back requesters (2..8).
- DATA_W, 65, write data width; matches the bank word.
- IDX_W, 8, register index width (256 registers).
- ADDR_W, 65, bank address width; the index occupies bits [IDX_W:1].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  freezes arbitration; no grants while high.
- req_valid  in  N_REQ  per-requester write request.
- req_idx  in  N_REQ*IDX_W  destination index; slice i is bits [i*IDX_W +: IDX_W].
- req_data  in  N_REQ*DATA_W  write data; slice i is bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant; combinational.
- issue_en  in  1  marks a register as having a write in flight.
- issue_idx  in  IDX_W  register being marked.
- chk_idx1  in  IDX_W  hazard query, read port 1.
- chk_idx2  in  IDX_W  hazard query, read port 2.
- chk_busy1  out  1  query 1 result; combinational.
- chk_busy2  out  1  query 2 result; combinational.
- write_en  out  1  to bank write_en; registered.
- write_address  out  ADDR_W  to bank; registered; value {zeros, idx, 1'b0}.
- write_data  out  DATA_W  to bank; registered.
- busy_any  out  1  OR of all scoreboard bits; registered-state based.

Behaviour:
- Arbitration
  - Search starts at pointer ptr (0..N_REQ-1). The first i (mod N_REQ) at or after ptr with req_valid[i]=1 gets req_ready[i]=1.
  - At most one ready bit is high. All ready bits are 0 when hold=1 or no request is valid.
  - req_ready may depend combinationally on req_valid.
  - Transfer occurs on valid&ready. A requester holds valid, idx and data stable until it is accepted.
  - On a transfer by requester g: ptr <= (g+1) mod N_REQ. With no transfer, ptr is unchanged.
- Write port
  - In the cycle after a transfer: write_en=1, write_address={zeros, req_idx[g], 1'b0}, write_data=req_data[g]. Latency is 1 cycle, throughput 1 write per cycle.
  - With no transfer: write_en=0, and write_address/write_data hold their last values.
- Scoreboard, busy[255:0]
  - issue_en sets busy[issue_idx] at the next edge.
  - A transfer clears busy[req_idx[g]] at the next edge.
  - Same index set and cleared in the same cycle: set wins (a newer producer is pending).
  - Writes to an index whose busy bit is 0 are legal and leave it 0.
- Hazard check
  - chk_busyK = busy[chk_idxK] | (write_en & write_address[IDX_W:1]==chk_idxK).
  - The second term covers the cycle in which the bank write has not yet landed.
- Reset (rst=1 at a clock edge)
  - ptr=0, busy all 0, write_en=0, write_address=0, write_data=0.
  - A transfer in the reset cycle is dropped. The requester re-presents after reset.
  - While rst=1, req_ready=0.
- Boundaries
  - All N_REQ valid continuously gives strict rotation 0,1,..,N_REQ-1,0.
  - A single valid requester is granted every cycle.
  - Pointer wrap: from N_REQ-1 it goes to 0.
  - hold=1 mid-stream: the write already registered still issues next cycle; no new grants are made.

Decomposition:
- Shared package reg_bank_pkg holds:
  - constants DATA_W=65, IDX_W=8, NUM_REGS=256, ADDR_W=65;
  - function idx_to_addr(idx) -> {zeros, idx, 1'b0};
  - function addr_to_idx(addr) -> addr[8:1].
- One sub-module: rr_arbiter (N parameter). Inputs: valid vector, ptr, enable. Outputs: one-hot grant and encoded grant index. Purely combinational.
- The pointer register, output registers and scoreboard stay in reg_wb_sched.

Test Plan:
- Reset, then single request: req0 idx=5, data=65'h1_0000_0000_DEAD_BEEF -> req_ready=001 that cycle; next cycle write_en=1, write_address=65'h00A, write_data matches; bank read of index 5 returns the data.
- All three valid for 6 cycles -> grants 0,1,2,0,1,2; write_en high 6 consecutive cycles; indices in the same order.
- issue_en idx=9, then chk_idx1=9 -> chk_busy1=1 until the write to 9 is accepted. chk_busy1 stays 1 in the write_en cycle and is 0 the cycle after.
- Same cycle issue_en idx=7 and accepted write to 7 -> busy[7]=1 afterwards, busy_any=1.
- hold=1 with req1 valid for 3 cycles -> req_ready=000, write_en=0, ptr unchanged. hold drops -> req1 granted immediately.
- rst asserted in a transfer cycle with busy[3]=1 -> next cycle write_en=0, chk_busy for 3 = 0, busy_any=0, ptr=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 256-entry, 65-bit register bank and its
// write-back scheduler: word/index widths and index <-> address mapping.
package reg_bank_pkg;

    localparam int DATA_W   = 65;
    localparam int IDX_W    = 8;
    localparam int NUM_REGS = 256;
    localparam int ADDR_W   = 65;

    typedef logic [IDX_W-1:0] reg_idx_t;

    // The bank address carries the register index in bits [IDX_W:1], bit 0 is zero.
    function automatic logic [ADDR_W-1:0] idx_to_addr(input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-IDX_W-1){1'b0}}, idx, 1'b0};
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W:1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester at or after
// the pointer (wrapping modulo N) is granted, as a one-hot vector plus index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_enable,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_cand;

    // Walk the requesters in priority order starting at the pointer; stop at the first valid one.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = PTR_W'((int'(i_ptr) + k) % N);
            if (i_enable && !w_found && i_valid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_sched.sv
// Write-back scheduler for the register bank: arbitrates the single write
// port among N_REQ requesters, registers the bank write, and keeps a
// per-register pending-write scoreboard for read-after-write hazard checks.
module reg_wb_sched #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int IDX_W  = reg_bank_pkg::IDX_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*IDX_W-1:0]  req_idx,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    issue_en,
    input  logic [IDX_W-1:0]        issue_idx,
    input  logic [IDX_W-1:0]        chk_idx1,
    input  logic [IDX_W-1:0]        chk_idx2,
    output logic                    chk_busy1,
    output logic                    chk_busy2,
    output logic                    write_en,
    output logic [ADDR_W-1:0]       write_address,
    output logic [DATA_W-1:0]       write_data,
    output logic                    busy_any
);

    import reg_bank_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]    r_ptr;
    logic                r_write_en;
    logic [ADDR_W-1:0]   r_write_address;
    logic [DATA_W-1:0]   r_write_data;
    logic [NUM_REGS-1:0] r_busy;

    logic [N_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]    w_grant_idx;
    logic                w_enable;
    logic                w_xfer;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [DATA_W-1:0]   w_sel_data;
    logic [IDX_W-1:0]    w_wr_idx;

    // No grants while frozen or in reset, so a reset cycle never consumes a request.
    assign w_enable = !hold && !rst;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_valid     (req_valid),
        .i_ptr       (r_ptr),
        .i_enable    (w_enable),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign req_ready  = w_grant;
    assign w_xfer     = |(w_grant & req_valid);
    assign w_sel_idx  = req_idx[w_grant_idx*IDX_W +: IDX_W];
    assign w_sel_data = req_data[w_grant_idx*DATA_W +: DATA_W];

    // Move the priority pointer just past the requester that won, wrapping at N_REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_grant_idx == PTR_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Register the accepted write for the bank; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_en      <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
        end else begin
            r_write_en <= w_xfer;
            if (w_xfer) begin
                r_write_address <= idx_to_addr(w_sel_idx);
                r_write_data    <= w_sel_data;
            end
        end
    end

    // Scoreboard: the set is applied last so a newer producer outranks a completing write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_xfer) begin
                r_busy[w_sel_idx] <= 1'b0;
            end
            if (issue_en) begin
                r_busy[issue_idx] <= 1'b1;
            end
        end
    end

    // A register is still hazardous during the cycle its write is on the bank port.
    assign w_wr_idx  = addr_to_idx(r_write_address);
    assign chk_busy1 = r_busy[chk_idx1] | (r_write_en && (w_wr_idx == chk_idx1));
    assign chk_busy2 = r_busy[chk_idx2] | (r_write_en && (w_wr_idx == chk_idx2));
    assign busy_any  = |r_busy;

    assign write_en      = r_write_en;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;

endmodule
